reg_file_sb: RTL and testbench



---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_clr_seq.sv | 65 ++++++
 rtl/reg_file_sb.sv | 127 ++++++++++++
 tb/tb_reg_file_sb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and sizing helpers for the scoreboarded register file.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clrState_t;

  localparam int DEF_DATA_W   = 32'sd16;
  localparam int DEF_NUM_REGS = 32'sd16;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Bulk-clear sequencer: walks every register index once, one per cycle.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  clrState_t         state_r, nextState_s;
  logic [ADDR_W-1:0] idx_r, nextIdx_s;

  // State and index registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      idx_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= nextState_s;
      idx_r   <= nextIdx_s;
    end
  end

  // Next-state and index update
  always_comb begin
    nextState_s = state_r;
    nextIdx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          nextState_s = CLEAR;
          nextIdx_s   = {ADDR_W{1'b0}};
        end else begin
          nextState_s = IDLE;
          nextIdx_s   = idx_r;
        end
      end
      CLEAR: begin
        nextIdx_s = idx_r + ADDR_W'(1);
        if (idx_r == LAST_IDX) begin
          nextState_s = IDLE;
        end else begin
          nextState_s = CLEAR;
        end
      end
      default: begin
        nextState_s = IDLE;
        nextIdx_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign clr_busy = (state_r == CLEAR);
  assign clr_we   = (state_r == CLEAR);
  assign clr_idx  = idx_r;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two read ports, one bypassed write port, a pending
// scoreboard for issue and a bulk-clear sequencer for context reset.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int ZERO_REG = 32'sd0,
  parameter  int BYPASS   = 32'sd1,
  localparam int ADDR_W   = addr_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_conflict,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam bit                ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam bit                BYP_EN    = (BYPASS != 32'sd0);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0]   regMem_r [NUM_REGS];
  logic [NUM_REGS-1:0] pending_r;

  logic              clrWe_s;
  logic [ADDR_W-1:0] clrIdx_s;
  logic              wrOk_s, rsvOk_s, byp1_s, byp2_s;
  logic              commitEn_s;
  logic [ADDR_W-1:0] commitAddr_s;
  logic [DATA_W-1:0] commitData_s;

  reg_file_clr_seq #(.NUM_REGS(NUM_REGS)) uClrSeq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clrWe_s),
    .clr_idx  (clrIdx_s)
  );

  // Register 0 swallows writes and reservations when hardwired to zero.
  assign wrOk_s  = wr_en && !clr_busy && !(ZERO_EN && (wr_addr == ADDR_ZERO));
  assign rsvOk_s = rsv_en && !clr_busy && !(ZERO_EN && (rsv_addr == ADDR_ZERO));
  assign byp1_s  = BYP_EN && wrOk_s && (wr_addr == rd_addr1);
  assign byp2_s  = BYP_EN && wrOk_s && (wr_addr == rd_addr2);

  assign rsv_conflict = rsv_en && pending_r[rsv_addr];

  // Clear path has priority over the normal writeback path
  always_comb begin
    commitEn_s   = 1'b0;
    commitAddr_s = wr_addr;
    commitData_s = wr_data;
    if (clrWe_s) begin
      commitEn_s   = 1'b1;
      commitAddr_s = clrIdx_s;
      commitData_s = {DATA_W{1'b0}};
    end else begin
      commitEn_s   = wrOk_s;
      commitAddr_s = wr_addr;
      commitData_s = wr_data;
    end
  end

  // Storage and scoreboard update; a reservation beats a same-edge completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regMem_r[i] <= {DATA_W{1'b0}};
      end
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commitEn_s && (commitAddr_s == ADDR_W'(i))) begin
          regMem_r[i] <= commitData_s;
        end
        if (rsvOk_s && (rsv_addr == ADDR_W'(i))) begin
          pending_r[i] <= 1'b1;
        end else if (commitEn_s && (commitAddr_s == ADDR_W'(i))) begin
          pending_r[i] <= 1'b0;
        end
      end
    end
  end

  // Read ports with zero-register override and write-through bypass
  always_comb begin
    rd_data1 = regMem_r[rd_addr1];
    rd_busy1 = pending_r[rd_addr1];
    if (ZERO_EN && (rd_addr1 == ADDR_ZERO)) begin
      rd_data1 = {DATA_W{1'b0}};
      rd_busy1 = 1'b0;
    end else if (byp1_s) begin
      rd_data1 = wr_data;
      rd_busy1 = 1'b0;
    end else begin
      rd_data1 = regMem_r[rd_addr1];
      rd_busy1 = pending_r[rd_addr1];
    end

    rd_data2 = regMem_r[rd_addr2];
    rd_busy2 = pending_r[rd_addr2];
    if (ZERO_EN && (rd_addr2 == ADDR_ZERO)) begin
      rd_data2 = {DATA_W{1'b0}};
      rd_busy2 = 1'b0;
    end else if (byp2_s) begin
      rd_data2 = wr_data;
      rd_busy2 = 1'b0;
    end else begin
      rd_data2 = regMem_r[rd_addr2];
      rd_busy2 = pending_r[rd_addr2];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised bench for reg_file_sb: instance 0 is the default build,
// instance 1 has a hardwired zero register; both see identical stimulus.
module tb_reg_file_sb;

  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [15:0] wr_data;
  logic        wr_en, rsv_en, clr_req;

  logic [1:0][15:0] rdData1, rdData2;
  logic [1:0]       rdBusy1, rdBusy2, rsvConflict, clrBusy;

  int compared = 0;
  int mismatched = 0;

  // Reference model: register contents, pending flags, clear cycles remaining
  logic [15:0] mMem [2][NR];
  logic        mPend [2][NR];
  int          mClrLeft;

  reg_file_sb #(.ZERO_REG(0), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rdData1[0]), .rd_data2(rdData2[0]), .rd_busy1(rdBusy1[0]), .rd_busy2(rdBusy2[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_conflict(rsvConflict[0]), .clr_req(clr_req), .clr_busy(clrBusy[0])
  );

  reg_file_sb #(.ZERO_REG(1), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rdData1[1]), .rd_data2(rdData2[1]), .rd_busy1(rdBusy1[1]), .rd_busy2(rdBusy2[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_conflict(rsvConflict[1]), .clr_req(clr_req), .clr_busy(clrBusy[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  function automatic bit isZeroReg(input int z, input logic [3:0] a);
    return (z == 1) && (a == 4'd0);
  endfunction

  function automatic bit wrOkM(input int z);
    return wr_en && (mClrLeft == 0) && !isZeroReg(z, wr_addr);
  endfunction

  function automatic bit rsvOkM(input int z);
    return rsv_en && (mClrLeft == 0) && !isZeroReg(z, rsv_addr);
  endfunction

  function automatic logic [15:0] expData(input int z, input logic [3:0] a);
    if (isZeroReg(z, a)) return 16'h0000;
    if (wrOkM(z) && (wr_addr == a)) return wr_data;
    return mMem[z][a];
  endfunction

  function automatic logic expBusy(input int z, input logic [3:0] a);
    if (isZeroReg(z, a)) return 1'b0;
    if (wrOkM(z) && (wr_addr == a)) return 1'b0;
    return mPend[z][a];
  endfunction

  // Model state update at each edge (or asynchronous reset)
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int z = 0; z < 2; z++)
        for (int i = 0; i < NR; i++) begin
          mMem[z][i]  <= 16'h0000;
          mPend[z][i] <= 1'b0;
        end
      mClrLeft <= 0;
    end else if (mClrLeft > 0) begin
      for (int z = 0; z < 2; z++) begin
        mMem[z][NR - mClrLeft]  <= 16'h0000;
        mPend[z][NR - mClrLeft] <= 1'b0;
      end
      mClrLeft <= mClrLeft - 1;
    end else begin
      for (int z = 0; z < 2; z++) begin
        if (wrOkM(z)) begin
          mMem[z][wr_addr]  <= wr_data;
          mPend[z][wr_addr] <= 1'b0;
        end
        if (rsvOkM(z)) mPend[z][rsv_addr] <= 1'b1;
      end
      if (clr_req) mClrLeft <= NR;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    for (int z = 0; z < 2; z++) begin
      check("rd_data1", z, rdData1[z], expData(z, rd_addr1));
      check("rd_data2", z, rdData2[z], expData(z, rd_addr2));
      check("rd_busy1", z, 16'(rdBusy1[z]), 16'(expBusy(z, rd_addr1)));
      check("rd_busy2", z, 16'(rdBusy2[z]), 16'(expBusy(z, rd_addr2)));
      check("rsv_conflict", z, 16'(rsvConflict[z]), 16'(rsv_en && mPend[z][rsv_addr]));
      check("clr_busy", z, 16'(clrBusy[z]), 16'(mClrLeft > 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic readAllZero(input string tag);
    for (int i = 0; i < NR; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(NR - 1 - i);
      #1;
      for (int z = 0; z < 2; z++) begin
        check({tag, "_data1"}, z, rdData1[z], 16'h0000);
        check({tag, "_data2"}, z, rdData2[z], 16'h0000);
        check({tag, "_busy1"}, z, 16'(rdBusy1[z]), 16'h0000);
        check({tag, "_busy2"}, z, 16'(rdBusy2[z]), 16'h0000);
        check({tag, "_clrbusy"}, z, 16'(clrBusy[z]), 16'h0000);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    rd_addr1 = 4'd0; rd_addr2 = 4'd0; wr_addr = 4'd0; rsv_addr = 4'd0; wr_data = 16'h0000;
    idleInputs();
    #1 rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    readAllZero("reset");

    // Write-through bypass then registered value
    step();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_addr1 = 4'd3; rd_addr2 = 4'd9;
    #1 check("bypass_same_cycle", 0, rdData1[0], 16'hBEEF);
    step();
    wr_en = 1'b0;
    #1 check("stored_next_cycle", 0, rdData1[0], 16'hBEEF);

    // Reservation, conflict, completion
    rsv_en = 1'b1; rsv_addr = 4'd5;
    step();
    rsv_en = 1'b0; rd_addr2 = 4'd5;
    #1 check("busy_after_rsv", 0, 16'(rdBusy2[0]), 16'h0001);
    rsv_en = 1'b1;
    #1 check("conflict_rerserve", 0, 16'(rsvConflict[0]), 16'h0001);
    step();
    rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0042;
    #1 check("busy_masked_by_write", 0, 16'(rdBusy2[0]), 16'h0000);
    step();
    wr_en = 1'b0;
    #1 check("busy_cleared", 0, 16'(rdBusy2[0]), 16'h0000);
    check("data_after_complete", 0, rdData2[0], 16'h0042);

    // Same-cycle reserve and write to an already pending register
    rsv_en = 1'b1; rsv_addr = 4'd7;
    step();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1234;
    step();
    idleInputs(); rd_addr1 = 4'd7;
    #1 check("set_wins_busy", 0, 16'(rdBusy1[0]), 16'h0001);
    check("set_wins_data", 0, rdData1[0], 16'h1234);

    // Fill, then bulk clear with a dropped write in clear cycle 4
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'(i) * 16'h1111 + 16'h0001;
      step();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0; wr_addr = 4'd2; wr_data = 16'hAAAA;
    n = 0;
    while (clrBusy[0] && n < 40) begin
      n++;
      wr_en = (n == 4);
      step();
    end
    wr_en = 1'b0;
    check("clear_cycles", 0, 16'(n), 16'd16);
    readAllZero("after_clear");

    // Hardwired zero register ignores write and reservation
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_addr = 4'd0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    #1 check("zero_bypass_data", 1, rdData1[1], 16'h0000);
    check("zero_bypass_busy", 1, 16'(rdBusy1[1]), 16'h0000);
    step();
    idleInputs();
    #1 check("zero_data", 1, rdData2[1], 16'h0000);
    check("zero_busy", 1, 16'(rdBusy2[1]), 16'h0000);
    check("plain_reg0_data", 0, rdData2[0], 16'hFFFF);
    rsv_en = 1'b1; rsv_addr = 4'd0;
    #1 check("zero_no_conflict", 1, 16'(rsvConflict[1]), 16'h0000);
    check("plain_reg0_conflict", 0, 16'(rsvConflict[0]), 16'h0001);
    rsv_en = 1'b0;

    // Randomised traffic
    repeat (1500) begin
      wr_en    = ($urandom_range(0, 1) == 1);
      rsv_en   = ($urandom_range(0, 9) < 4);
      clr_req  = ($urandom_range(0, 63) == 0);
      wr_addr  = 4'($urandom_range(0, NR - 1));
      rsv_addr = 4'($urandom_range(0, NR - 1));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, NR - 1));
      rd_addr2 = 4'($urandom_range(0, NR - 1));
      wr_data  = 16'($urandom);
      step();
    end
    idleInputs();
    n = 0;
    while (clrBusy[0] && n < 40) begin
      step();
      n++;
    end
    check("idle_before_abort", 0, 16'(clrBusy[0]), 16'h0000);

    // Make sure storage is non-zero, then abort a clear at cycle 8 with reset
    for (int i = 0; i < NR; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'hC000 | 16'(i);
      step();
    end
    wr_en = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (7) step();
    check("busy_cycle8", 0, 16'(clrBusy[0]), 16'h0001);
    #2 rst = 1'b0;
    #1 check("abort_busy", 0, 16'(clrBusy[0]), 16'h0000);
    check("abort_busy", 1, 16'(clrBusy[1]), 16'h0000);
    repeat (2) step();
    rst = 1'b1;
    readAllZero("after_abort");

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
